// File: rtl/pkt_deframer_if.sv
// Stream interface for the deframer: 256-bit packet words in, 512-bit payload beats out.
// The master drives data/valid/last/user and the slave returns ready.
interface pkt_deframer_if #(
  parameter int unsigned DataW = 256,
  parameter int unsigned UserW = 32
);
  logic [DataW-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;
  logic [UserW-1:0] tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/pkt_deframer.sv
// Packet deframer: header, payload word pairs joined into 512-bit beats, footer check.
// Framing statistics are exported; the output stream carries no error indication.
module pkt_deframer #(
  parameter int unsigned BEATS_PER_PACKET = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  pkt_deframer_if.slave        axis_in,
  pkt_deframer_if.master       axis_out,
  input  logic                 clear_stats,
  output logic [31:0]          pkt_count,
  output logic [31:0]          err_count,
  output logic [31:0]          last_err_id,
  output logic                 error
);

  localparam int unsigned CntW = $clog2(BEATS_PER_PACKET + 1);

  typedef enum logic [1:0] {StHdr, StLo, StHi, StFtr} state_e;

  state_e          state_q, state_d;
  logic            active_q;
  logic            in_ready, in_acc, ftr_err;

  logic [31:0]     req_id_q, req_id_d;
  logic            hdr_bad_q, hdr_bad_d;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
  logic [255:0]    hold_q, hold_d;
  logic [511:0]    out_data_q, out_data_d;
  logic [31:0]     out_user_q, out_user_d;
  logic            out_last_q, out_last_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     pkt_count_q, pkt_count_d;
  logic [31:0]     err_count_q, err_count_d;
  logic [31:0]     last_err_id_q, last_err_id_d;
  logic            error_q, error_d;

  logic unused_in;
  assign unused_in = ^{axis_in.tlast, axis_in.tuser};

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= StHdr;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (in_acc) begin
      unique case (state_q)
        StHdr:   state_d = StLo;
        StLo:    state_d = StHi;
        StHi:    state_d = (beat_cnt_q == CntW'(1)) ? StFtr : StLo;
        StFtr:   state_d = StHdr;
        default: state_d = StHdr;
      endcase
    end
  end

  // Output logic; active_q holds ready low until the first edge after reset release
  always_comb begin
    in_ready = active_q;
    if (state_q == StHi) in_ready = active_q & (~out_valid_q | axis_out.tready);
    in_acc = axis_in.tvalid & in_ready;
  end

  assign ftr_err = (axis_in.tdata[31:0] != req_id_q) || (axis_in.tdata[255:32] != '0) ||
                   hdr_bad_q;

  always_comb begin
    req_id_d      = req_id_q;
    hdr_bad_d     = hdr_bad_q;
    beat_cnt_d    = beat_cnt_q;
    hold_d        = hold_q;
    out_data_d    = out_data_q;
    out_user_d    = out_user_q;
    out_last_d    = out_last_q;
    out_valid_d   = out_valid_q;
    pkt_count_d   = pkt_count_q;
    err_count_d   = err_count_q;
    last_err_id_d = last_err_id_q;
    error_d       = error_q;

    if (out_valid_q && axis_out.tready) out_valid_d = 1'b0;

    if (in_acc) begin
      unique case (state_q)
        StHdr: begin
          req_id_d   = axis_in.tdata[31:0];
          hdr_bad_d  = (axis_in.tdata[255:32] != '0);
          beat_cnt_d = CntW'(BEATS_PER_PACKET);
        end
        StLo: hold_d = axis_in.tdata;
        StHi: begin
          out_data_d  = {hold_q, axis_in.tdata};
          out_user_d  = req_id_q;
          out_last_d  = (beat_cnt_q == CntW'(1));
          out_valid_d = 1'b1;
          beat_cnt_d  = beat_cnt_q - CntW'(1);
        end
        StFtr: begin
          pkt_count_d = sat_inc(pkt_count_q);
          if (ftr_err) begin
            err_count_d   = sat_inc(err_count_q);
            last_err_id_d = req_id_q;
            error_d       = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Clear wins over a footer update in the same cycle
    if (clear_stats) begin
      pkt_count_d   = '0;
      err_count_d   = '0;
      last_err_id_d = '0;
      error_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active_q      <= 1'b0;
      req_id_q      <= '0;
      hdr_bad_q     <= 1'b0;
      beat_cnt_q    <= '0;
      hold_q        <= '0;
      out_data_q    <= '0;
      out_user_q    <= '0;
      out_last_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      pkt_count_q   <= '0;
      err_count_q   <= '0;
      last_err_id_q <= '0;
      error_q       <= 1'b0;
    end else begin
      active_q      <= 1'b1;
      req_id_q      <= req_id_d;
      hdr_bad_q     <= hdr_bad_d;
      beat_cnt_q    <= beat_cnt_d;
      hold_q        <= hold_d;
      out_data_q    <= out_data_d;
      out_user_q    <= out_user_d;
      out_last_q    <= out_last_d;
      out_valid_q   <= out_valid_d;
      pkt_count_q   <= pkt_count_d;
      err_count_q   <= err_count_d;
      last_err_id_q <= last_err_id_d;
      error_q       <= error_d;
    end
  end

  assign axis_in.tready  = in_ready;
  assign axis_out.tdata  = out_data_q;
  assign axis_out.tuser  = out_user_q;
  assign axis_out.tlast  = out_last_q;
  assign axis_out.tvalid = out_valid_q;
  assign pkt_count       = pkt_count_q;
  assign err_count       = err_count_q;
  assign last_err_id     = last_err_id_q;
  assign error           = error_q;

endmodule

// File: tb/tb_pkt_deframer.sv
// Randomized bench for pkt_deframer: packet-level reference model feeds a beat scoreboard
// that an independent output monitor drains; statistics are checked against the model.
module tb_pkt_deframer;

  localparam int unsigned Beats = 32;

  typedef struct {
    logic [511:0] data;
    logic [31:0]  user;
    logic         last;
  } beat_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        clear_stats = 1'b0;
  logic [31:0] pkt_count, err_count, last_err_id;
  logic        error;

  pkt_deframer_if #(.DataW(256), .UserW(32)) in_if ();
  pkt_deframer_if #(.DataW(512), .UserW(32)) out_if ();

  pkt_deframer #(.BEATS_PER_PACKET(Beats)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .axis_in     (in_if),
    .axis_out    (out_if),
    .clear_stats (clear_stats),
    .pkt_count   (pkt_count),
    .err_count   (err_count),
    .last_err_id (last_err_id),
    .error       (error)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  beat_t exp_q[$];
  bit    rand_ready = 1'b0;
  bit    gap_en = 1'b0;

  // Reference statistics
  logic [31:0] m_pkt = '0, m_err = '0, m_id = '0;
  logic        m_error = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1 out_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: pops the scoreboard on each handshake and checks stall stability
  bit           stalled = 1'b0;
  logic [511:0] held_data;
  logic [31:0]  held_user;
  logic         held_last;
  always @(negedge clk) begin
    if (!resetn) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 512'(out_if.tvalid), 512'd1);
        chk("stall_data", out_if.tdata, held_data);
        chk("stall_user", 512'(out_if.tuser), 512'(held_user));
        chk("stall_last", 512'(out_if.tlast), 512'(held_last));
      end
      if (out_if.tvalid && out_if.tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h expected=none", out_if.tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", out_if.tdata, e.data);
          chk("beat_user", 512'(out_if.tuser), 512'(e.user));
          chk("beat_last", 512'(out_if.tlast), 512'(e.last));
        end
      end
      stalled   = out_if.tvalid && !out_if.tready;
      held_data = out_if.tdata;
      held_user = out_if.tuser;
      held_last = out_if.tlast;
    end
  end

  function automatic logic [255:0] rand256();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic idle_gap();
    if (gap_en) begin
      int n;
      n = $urandom_range(0, 1);
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [255:0] w);
    int n;
    n = 0;
    in_if.tdata  = w;
    in_if.tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_if.tready) break;
      n++;
      if (n > 1000) begin
        checks++;
        failures++;
        $display("FAIL input_timeout actual=stalled expected=accept");
        in_if.tvalid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1 in_if.tvalid = 1'b0;
  endtask

  // Sends a whole packet; expected beats and statistics come from the framing rules
  task automatic send_packet(input logic [255:0] hdr, input logic [255:0] ftr,
                             input bit use_index, input bit clr);
    logic [255:0] lo, hi;
    beat_t        b;
    bit           bad;
    idle_gap();
    send_word(hdr);
    for (int k = 0; k < int'(Beats); k++) begin
      lo = use_index ? 256'(2 * k)     : rand256();
      hi = use_index ? 256'(2 * k + 1) : rand256();
      b.data = {lo, hi};
      b.user = hdr[31:0];
      b.last = (k == int'(Beats) - 1);
      exp_q.push_back(b);
      idle_gap();
      send_word(lo);
      idle_gap();
      send_word(hi);
    end
    idle_gap();
    clear_stats = clr;
    send_word(ftr);
    clear_stats = 1'b0;
    bad = (ftr[31:0] != hdr[31:0]) || (ftr[255:32] != 0) || (hdr[255:32] != 0);
    if (clr) begin
      m_pkt = '0; m_err = '0; m_id = '0; m_error = 1'b0;
    end else begin
      m_pkt++;
      if (bad) begin
        m_err++;
        m_id    = hdr[31:0];
        m_error = 1'b1;
      end
    end
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_pkt_count"}, 512'(pkt_count), 512'(m_pkt));
    chk({tag, "_err_count"}, 512'(err_count), 512'(m_err));
    chk({tag, "_last_err_id"}, 512'(last_err_id), 512'(m_id));
    chk({tag, "_error"}, 512'(error), 512'(m_error));
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_if.tvalid) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_pending_beats"}, 512'(exp_q.size()), 512'd0);
  endtask

  initial begin
    logic [255:0] hdr, ftr;
    logic [31:0]  id;
    in_if.tvalid  = 1'b0;
    in_if.tdata   = '0;
    in_if.tlast   = 1'b0;
    in_if.tuser   = '0;
    out_if.tready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 512'(in_if.tready), 512'd0);
    chk("rst_out_valid", 512'(out_if.tvalid), 512'd0);
    chk("rst_out_last", 512'(out_if.tlast), 512'd0);
    chk("rst_out_data", out_if.tdata, 512'd0);
    chk("rst_out_user", 512'(out_if.tuser), 512'd0);
    chk_stats("rst");
    resetn = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_release", 512'(in_if.tready), 512'd1);

    // Indexed payload, ID 0xA5, no backpressure
    send_packet(256'h0A5, 256'h0A5, 1'b1, 1'b0);
    drain("idx");
    chk_stats("idx");

    // Footer ID mismatch
    send_packet(256'h0A5, 256'h0A6, 1'b0, 1'b0);
    drain("ftr_bad");
    chk_stats("ftr_bad");

    // Non-zero header upper bits with matching footer
    hdr = 256'h0000_0001_0000_0033;
    send_packet(hdr, 256'h33, 1'b0, 1'b0);
    drain("hdr_bad");
    chk_stats("hdr_bad");

    // Standalone clear, then 100 packets with random backpressure and input gaps
    clear_stats = 1'b1;
    @(posedge clk);
    #1 clear_stats = 1'b0;
    m_pkt = '0; m_err = '0; m_id = '0; m_error = 1'b0;
    chk_stats("clear");
    rand_ready = 1'b1;
    gap_en     = 1'b1;
    for (int p = 0; p < 100; p++) begin
      id  = $urandom;
      ftr = 256'(id);
      if ($urandom_range(0, 7) == 0) ftr[$urandom_range(0, 255)] ^= 1'b1;
      send_packet(256'(id), ftr, 1'b0, 1'b0);
    end
    drain("stress");
    chk_stats("stress");
    chk("stress_pkt_100", 512'(pkt_count), 512'd100);
    rand_ready = 1'b0;
    gap_en     = 1'b0;

    // Reset after header plus 10 payload words
    @(posedge clk);
    #1;
    send_word(256'h77);
    for (int k = 0; k < 5; k++) begin
      beat_t b;
      hdr = rand256();
      ftr = rand256();
      b.data = {hdr, ftr};
      b.user = 32'h77;
      b.last = 1'b0;
      exp_q.push_back(b);
      send_word(hdr);
      send_word(ftr);
    end
    #2 resetn = 1'b0;
    #1;
    exp_q.delete();
    m_pkt = '0; m_err = '0; m_id = '0; m_error = 1'b0;
    chk("midrst_out_valid", 512'(out_if.tvalid), 512'd0);
    chk("midrst_in_ready", 512'(in_if.tready), 512'd0);
    chk_stats("midrst");
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    send_packet(256'h1234, 256'h1234, 1'b0, 1'b0);
    drain("after_rst");
    chk_stats("after_rst");

    // Clear in the same cycle as an erroring footer, then one good packet
    send_packet(256'h55, 256'h56, 1'b0, 1'b1);
    drain("clr_err");
    chk_stats("clr_err");
    send_packet(256'h99, 256'h99, 1'b0, 1'b0);
    drain("post_clr");
    chk_stats("post_clr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pkt_deframer.md
# pkt_deframer

Downstream consumer of the 256-bit request-response packet stream. It parses each packet: one header word, 2×BEATS_PER_PACKET payload words, one footer word. It rejoins payload word pairs into 512-bit beats on an AXI-Stream output with TLAST, and checks packet framing. Packet, error and last-error statistics are exported to the register file.

## Interface
Parameters:
- BEATS_PER_PACKET, 32, number of 512-bit payload beats per packet (must be ≥1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- resetn  input  1  reset; asynchronous and active-low.
- AXIS_IN_TDATA  input  256  packet stream data.
- AXIS_IN_TVALID  input  1  packet stream valid.
- AXIS_IN_TREADY  output  1  packet stream ready.
- AXIS_OUT_TDATA  output  512  reassembled payload beat.
- AXIS_OUT_TVALID  output  1  output valid.
- AXIS_OUT_TLAST  output  1  high on the final payload beat of a packet.
- AXIS_OUT_TUSER  output  32  request ID from the packet header.
- AXIS_OUT_TREADY  input  1  output ready.
- clear_stats  input  1  single-cycle pulse that clears counters and the sticky error.
- pkt_count  output  32  footers received.
- err_count  output  32  packets with a framing error.
- last_err_id  output  32  header ID of the most recent errored packet.
- error  output  1  sticky; set on any framing error.

## Operation
- Input handshake: a beat is taken when AXIS_IN_TVALID & AXIS_IN_TREADY. Output handshake: AXIS_OUT_TVALID & AXIS_OUT_TREADY.
- State machine: HDR → LO → HI → (LO, or FTR after the last pair) → HDR.
- HDR: AXIS_IN_TREADY=1.
  - On accept, req_id ← TDATA[31:0].
  - hdr_bad ← (TDATA[255:32] != 0).
  - beat_cnt ← BEATS_PER_PACKET.
  - Go to LO.
- LO: AXIS_IN_TREADY=1.
  - On accept, hold_word ← TDATA.
  - Go to HI.
- HI: AXIS_IN_TREADY = !AXIS_OUT_TVALID | AXIS_OUT_TREADY. This is combinational from AXIS_OUT_TREADY.
  - On accept, the output register loads:
    - TDATA[511:256] ← hold_word
    - TDATA[255:0] ← input word
    - TUSER ← req_id
    - TLAST ← (beat_cnt==1)
    - TVALID ← 1
  - beat_cnt decrements.
  - Go to FTR if beat_cnt==1, otherwise go to LO.
- FTR: AXIS_IN_TREADY=1. On accept:
  - pkt_count increments.
  - A footer error is TDATA[31:0] != req_id, TDATA[255:32] != 0, or hdr_bad.
  - On a footer error: err_count increments, last_err_id ← req_id, error ← 1.
  - Go to HDR.
- Output register: TVALID clears on output handshake unless it is reloaded in the same cycle. TDATA, TUSER and TLAST hold their values while TVALID=1 and TREADY=0.
- Payload contents are never checked. The output stream carries no error indication; errors are reported through statistics only.
- Counters saturate at 0xFFFF_FFFF.
- clear_stats clears pkt_count, err_count, last_err_id and error. It wins over a simultaneous footer update, so that event is lost.
- There is no resynchronisation. After a framing error the block keeps counting words; alignment is restored only by reset.

## Timing
- Reset values:
  - AXIS_IN_TREADY=0 while resetn=0. It goes to 1 in the first cycle after release (state HDR).
  - AXIS_OUT_TVALID=0, AXIS_OUT_TLAST=0, AXIS_OUT_TDATA=0, AXIS_OUT_TUSER=0.
  - pkt_count=0, err_count=0, last_err_id=0, error=0. State=HDR.
- Latency: an output beat is valid in the cycle after its HI-half input is accepted.
- Throughput: with no backpressure, one input word per cycle. A packet occupies 2×BEATS_PER_PACKET+2 cycles, and output bandwidth is one beat per two cycles.
- Backpressure: the output register is single-entry. LO acceptance does not depend on the output side. HI stalls only while the output is full and not draining.
- Statistics update in the cycle after the footer is accepted.
- Reset mid-packet (asynchronous assert): the partial packet is discarded, the output beat is dropped, and statistics are cleared. Parsing resumes at HDR.
- Simultaneous output drain and HI accept: the output register reloads and TVALID stays 1. No bubble.

## Test plan
- Reset is released, then one packet with ID 0x0000_00A5 is sent, with payload words w0..w63 equal to their index and TREADY held at 1. Required response:
  - 32 output beats, with beat k = {2k, 2k+1}.
  - TUSER=0xA5 on every beat; TLAST only on beat 31.
  - pkt_count=1, err_count=0.
- Footer 0x0000_00A6 after header 0xA5 → err_count=1, last_err_id=0xA5, error=1, and the output data is still delivered intact.
- Header with TDATA[255:32]=1 and a matching footer → err_count increments and error=1.
- AXIS_OUT_TREADY is toggled randomly (50%) across 100 back-to-back packets. Required response:
  - No lost or duplicated beats.
  - Output data is stable while stalled.
  - pkt_count=100.
- resetn is asserted after 10 payload words and then released. Required response:
  - TVALID=0 immediately.
  - The next full packet is parsed correctly from HDR, giving pkt_count=1.
- clear_stats is pulsed in the same cycle as an erroring footer is accepted → all statistics read 0 afterwards. A later good packet gives pkt_count=1.
